// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment count display.
// Holds the converter FSM states, the active-low hex glyph table and the blank code.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: 7-bit binary to hundreds/tens/ones BCD.
// Ports: clk, reset, start_i, bin_i[6:0] -> busy_o, done_o, hund_o[1:0], tens_o[3:0], ones_o[3:0].
module bin2bcd_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [6:0] bin_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [1:0] hund_o,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);
    import seg7_pkg::*;

    conv_state_e state_q, state_d;

    logic [6:0] shift_q, shift_d;
    logic [3:0] hund_q, hund_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;

    logic [3:0]  hund_adj, tens_adj, ones_adj;
    logic [18:0] shifted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // bit_cnt is checked before its decrement, so 7 -> 1 spans seven shifts
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_SHIFT;
            ST_SHIFT:  if (bit_cnt_q == 3'd1) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != ST_IDLE);
        done_o = (state_q == ST_COMMIT);
        hund_o = hund_q[1:0];
        tens_o = tens_q;
        ones_o = ones_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            hund_q    <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            hund_q    <= hund_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        hund_adj = (hund_q >= 4'd5) ? hund_q + 4'd3 : hund_q;
        tens_adj = (tens_q >= 4'd5) ? tens_q + 4'd3 : tens_q;
        ones_adj = (ones_q >= 4'd5) ? ones_q + 4'd3 : ones_q;
        shifted  = {hund_adj, tens_adj, ones_adj, shift_q} << 1;
    end

    always_comb begin
        shift_d   = shift_q;
        hund_d    = hund_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        bit_cnt_d = bit_cnt_q;
        if (state_q == ST_IDLE && start_i) begin
            shift_d   = bin_i;
            hund_d    = '0;
            tens_d    = '0;
            ones_d    = '0;
            bit_cnt_d = 3'd7;
        end else if (state_q == ST_SHIFT) begin
            {hund_d, tens_d, ones_d, shift_d} = shifted;
            bit_cnt_d = bit_cnt_q - 3'd1;
        end
    end

endmodule

// File: rtl/seg7_count_display.sv
// Decimal count plus hex timer on four multiplexed common-anode digits.
// Ports: clk, reset, timer_in[3:0], count_in[6:0] -> seg[6:0], an[3:0], conv_busy (outputs active-low except busy).
module seg7_count_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] timer_in,
    input  logic [6:0] count_in,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       conv_busy
);
    import seg7_pkg::*;

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(REFRESH_DIV - 1);

    logic [6:0]       last_count_q;
    logic [1:0]       d_hund_q;
    logic [3:0]       d_tens_q, d_ones_q;
    logic [3:0]       timer_q;
    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic [1:0]       scan_q, scan_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic       busy, done, start;
    logic [1:0] bcd_hund;
    logic [3:0] bcd_tens, bcd_ones;

    // Edits made while busy are picked up here once the FSM is back in IDLE
    assign start = !busy && (count_in != last_count_q);

    bin2bcd_seq u_conv (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .bin_i   (count_in),
        .busy_o  (busy),
        .done_o  (done),
        .hund_o  (bcd_hund),
        .tens_o  (bcd_tens),
        .ones_o  (bcd_ones)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_count_q <= '0;
            d_hund_q     <= '0;
            d_tens_q     <= '0;
            d_ones_q     <= '0;
            timer_q      <= '0;
        end else begin
            timer_q <= timer_in;
            if (start) last_count_q <= count_in;
            if (done) begin
                d_hund_q <= bcd_hund;
                d_tens_q <= bcd_tens;
                d_ones_q <= bcd_ones;
            end
        end
    end

    always_comb begin
        refresh_d = refresh_q + 1'b1;
        scan_d    = scan_q;
        if (refresh_q == TERM) begin
            refresh_d = '0;
            scan_d    = scan_q + 2'd1;
        end
    end

    // Glyph and anode are both derived from scan_d so they switch together
    always_comb begin
        seg_d = SEG_BLANK;
        unique case (scan_d)
            2'd0: seg_d = HEX_GLYPH[d_ones_q];
            2'd1: if (d_hund_q != 2'd0 || d_tens_q != 4'd0)
                      seg_d = HEX_GLYPH[d_tens_q];
            2'd2: if (d_hund_q != 2'd0)
                      seg_d = HEX_GLYPH[{2'b00, d_hund_q}];
            2'd3: seg_d = HEX_GLYPH[timer_q];
            default: seg_d = SEG_BLANK;
        endcase
        an_d = ~(4'b0001 << scan_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_q <= '0;
            scan_q    <= '0;
            seg_q     <= 7'b1000000;
            an_q      <= 4'b1110;
        end else begin
            refresh_q <= refresh_d;
            scan_q    <= scan_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign conv_busy = busy;

endmodule

// File: doc/seg7_count_display.md
# seg7_count_display

Downstream display stage for the controlled counter. Takes the 4-bit `timer` and 7-bit `control_counter` outputs, converts the 7-bit count to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes four common-anode seven-segment digits. Digits 2..0 show the count in decimal with leading-zero blanking. Digit 3 shows the timer as a hex digit.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. Legal range is ≥ 2.
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `timer_in`, input, 4: timer value from the controlled counter.
- `count_in`, input, 7: control_counter value, 0..127.
- `seg`, output, 7: segment drive, active-low; `seg[0]`=a … `seg[6]`=g.
- `an`, output, 4: digit enables, active-low, one-hot-zero.
- `conv_busy`, output, 1: high while the BCD conversion runs.

## Operation
- Conversion FSM states: IDLE, SHIFT, COMMIT.
- IDLE: when `count_in != last_count`, on that edge:
  - capture `count_in` into `shift_reg` and `last_count`;
  - clear the BCD scratch;
  - set `bit_cnt` = 7;
  - go to SHIFT.
- SHIFT, each cycle:
  - add 3 to each of the ones/tens/hundreds scratch nibbles that is ≥ 5;
  - then shift {hundreds, tens, ones, `shift_reg`} left by 1;
  - decrement `bit_cnt`;
  - go to COMMIT when `bit_cnt` reaches 1 on that edge, giving exactly 7 shifts.
- COMMIT: copy the scratch to the display digit registers `d_hund` (2 bits suffice, value 0..1), `d_tens` and `d_ones`, then return to IDLE.
- `conv_busy` = 1 in SHIFT and COMMIT.
- Changes to `count_in` while busy are ignored. They are caught by the IDLE compare on the first IDLE cycle after COMMIT, so the final value is always displayed.
- Refresh counter counts 0..`REFRESH_DIV`-1. At terminal count it wraps to 0 and `scan_idx` advances 0→1→2→3→0.
- Digit mapping:
  - idx 0: `d_ones`.
  - idx 1: `d_tens`, blanked if `d_hund`==0 and `d_tens`==0.
  - idx 2: `d_hund`, blanked if 0.
  - idx 3: `timer_in` hex glyph 0–F. `timer_in` is registered into `timer_q` every cycle, so the glyph reflects the value one cycle old.
- A blank digit drives `seg` = 7'h7F with its anode still enabled.
- `an` = ~(4'b0001 << `scan_idx`).

## Timing
- Reset values:
  - `seg` = 7'b1000000 (glyph "0");
  - `an` = 4'b1110;
  - `conv_busy` = 0;
  - `scan_idx` = 0, refresh counter = 0;
  - `last_count` = 0, all digits 0, `timer_q` = 0;
  - FSM = IDLE.
- `seg` and `an` are registered and update on the same edge, so there is no ghosting cycle between them.
- Conversion latency: a change seen in IDLE at edge N updates the digits at edge N+8 (1 capture + 7 SHIFT, committed on the COMMIT edge). The new glyph appears on `seg` at edge N+9 if that digit is selected.
- Reset mid-conversion aborts to IDLE with the digits cleared to 0. Reset deassertion with `count_in` ≠ 0 starts a conversion on the first clock edge.
- A refresh tick coinciding with COMMIT: the scan advance uses the already-committed digit registers from the next cycle on. No glitch is required beyond a one-cycle-stale glyph.
- Boundary: `count_in` 127 → digits 1,2,7. `count_in` 0 → only the ones digit shows "0".

## Structure
- Shared package `seg7_pkg`:
  - FSM state enum (IDLE/SHIFT/COMMIT);
  - 16-entry hex glyph constant array (active-low);
  - `SEG_BLANK` = 7'h7F.
- Sub-module `bin2bcd_seq` (7-bit in, 3 BCD nibbles out, `start`/`busy`/`done`) holds the FSM and shift-add-3 datapath.
- The top level holds the change detect, digit registers, refresh divider and scan mux.

## Test plan
Benches use `REFRESH_DIV`=4.
- Reset asserted mid-stream → `seg`=7'b1000000, `an`=4'b1110, `conv_busy`=0 immediately, without waiting for a clock edge.
- `count_in` 0→127 in IDLE → `conv_busy` high for 8 cycles; digits become 1/2/7; scan shows `an` 1110 "7", 1101 "2", 1011 "1".
- `count_in`=5 → tens and hundreds scans drive 7'h7F; ones shows "5". `count_in`=40 → hundreds blank, tens "4", ones "0".
- `count_in` stepping 10→11→12 on consecutive cycles while busy → after COMMIT a second conversion starts automatically; final digits are 0/1/2.
- `timer_in`=4'hA → on idx 3, `an`=4'b0111, `seg`=hex-A glyph; `timer_in`=4'hF → F glyph.
- Reset pulse during SHIFT of 99 → digits 0, FSM IDLE. After release, reconversion of 99 completes in 8 cycles.
